booth_mult_dispatcher: RTL and testbench
========================================

BOOTH_MULT_DISPATCHER -- requirements
Module: booth_mult_dispatcher

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width; product is 2*WIDTH.
REQ-002 SHALL have parameter TAG_W, default 4, request tag width.
REQ-003 SHALL have parameter DEPTH, default 8, power of two; maximum in-flight plus buffered results.
REQ-004 SHALL have one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  sole clock, all state on rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 req_valid  in  1  upstream request present.
REQ-008 req_ready  out  1  dispatcher accepts request this cycle.
REQ-009 req_a  in  WIDTH  multiplicand.
REQ-010 req_b  in  WIDTH  multiplier.
REQ-011 req_mode  in  2  sign mode; bit1 = a signed, bit0 = b signed.
REQ-012 req_tag  in  TAG_W  caller tag returned with the result.
REQ-013 mul_start  out  1  one-cycle start pulse to the multiplier.
REQ-014 mul_multiplicand, mul_multiplier  out  WIDTH each  registered operands.
REQ-015 mul_sign_mode  out  2  registered sign mode.
REQ-016 mul_busy  in  1  multiplier cannot take start.
REQ-017 mul_done  in  1  one-cycle result strobe; cannot be stalled.
REQ-018 mul_product  in  2*WIDTH  result, valid with mul_done.
REQ-019 rsp_valid  out  1  result available.
REQ-020 rsp_ready  in  1  downstream consumes result.
REQ-021 rsp_product  out  2*WIDTH  product at FIFO head.
REQ-022 rsp_tag  out  TAG_W  tag at FIFO head.
REQ-023 err_unexpected_done  out  1  sticky: mul_done with no outstanding request.

Function
REQ-024 SHALL drive req_ready = !rst && !mul_busy && (occupancy < DEPTH), where occupancy counts accepted requests not yet consumed at rsp.
REQ-025 SHALL accept on rising edge where req_valid && req_ready; the next cycle SHALL have mul_start = 1 with req_a/req_b/req_mode registered onto mul_* outputs.
REQ-026 SHALL hold mul_start high for exactly one cycle per accepted request; accepts in consecutive cycles are permitted while mul_busy is low.
REQ-027 SHALL hold mul_* operand outputs stable until the next accept.
REQ-028 SHALL push req_tag into a DEPTH-entry in-order tag FIFO on accept.
REQ-029 SHALL, on mul_done with non-empty tag FIFO, pop the head tag and push {mul_product, tag} into a DEPTH-entry result FIFO in the same edge.
REQ-030 SHALL present the result FIFO head combinationally (show-ahead); rsp_valid = result FIFO non-empty.
REQ-031 SHALL pop the result FIFO and decrement occupancy on rsp_valid && rsp_ready.
REQ-032 Occupancy SHALL be +1 on accept, -1 on rsp handshake, unchanged when both occur in the same cycle.
REQ-033 Because occupancy bounds both FIFOs, result FIFO SHALL never overflow; a mul_done arriving with a full result FIFO is unreachable and SHALL be asserted against.
REQ-034 SHALL, on mul_done with empty tag FIFO, drop the product and set err_unexpected_done until reset.
REQ-035 FIFO pointers SHALL wrap modulo DEPTH; full/empty SHALL be distinguished by an extra pointer bit.
REQ-036 Simultaneous mul_done push and rsp pop on the same result FIFO SHALL both take effect.
REQ-037 SHALL pass products unmodified; no arithmetic on the product path.

Reset
REQ-038 On rst, SHALL clear both FIFOs, occupancy, and err_unexpected_done, and drive mul_start = 0, mul_* operands = 0, rsp_valid = 0, req_ready = 0.
REQ-039 Reset mid-operation SHALL discard all outstanding tags and results; the multiplier SHALL be reset in the same cycle, and any later mul_done for a discarded request SHALL be treated as unexpected (REQ-034).

Verification
REQ-040 a=10, b=10, mode=11, tag=3 -> one mul_start pulse one cycle after accept; rsp_product=100, rsp_tag=3.
REQ-041 Back-to-back a=32767,b=1,mode=11,tag=0 then a=-32768,b=1,mode=11,tag=1 -> results in order: 32767 (tag 0), 0xFFFF8000 (tag 1).
REQ-042 a=0xFFFF, b=0xFFFF, mode=00 -> 0xFFFE0001; mode=11 -> 0x00000001.
REQ-043 rsp_ready=0, 10 requests offered -> exactly 8 accepted, req_ready low thereafter; raising rsp_ready drains 8 results in tag order and re-opens req_ready.
REQ-044 mul_done pulsed with no request outstanding -> err_unexpected_done=1, rsp_valid stays 0; cleared only by rst.
REQ-045 rst asserted after 3 of 5 burst requests accepted -> next cycle rsp_valid=0, occupancy=0, mul_start=0; a fresh request afterwards completes correctly.

Source files
------------

// File: rtl/booth_mult_dispatcher.sv
// Request dispatcher for a Booth multiplier: issues start pulses, tracks caller tags
// in order, and buffers tagged results in a show-ahead FIFO until consumed.
module booth_mult_dispatcher #(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4,
    parameter int DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [WIDTH-1:0]     req_a,
    input  logic [WIDTH-1:0]     req_b,
    input  logic [1:0]           req_mode,
    input  logic [TAG_W-1:0]     req_tag,
    output logic                 mul_start,
    output logic [WIDTH-1:0]     mul_multiplicand,
    output logic [WIDTH-1:0]     mul_multiplier,
    output logic [1:0]           mul_sign_mode,
    input  logic                 mul_busy,
    input  logic                 mul_done,
    input  logic [2*WIDTH-1:0]   mul_product,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [2*WIDTH-1:0]   rsp_product,
    output logic [TAG_W-1:0]     rsp_tag,
    output logic                 err_unexpected_done
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int RW = 2 * WIDTH + TAG_W;

    // Occupancy covers everything from accept until the result is consumed,
    // so bounding it by DEPTH keeps both FIFOs from overflowing.
    logic [PW-1:0]        occ_reg, occ_next;

    logic                 mul_start_reg;
    logic [WIDTH-1:0]     mul_a_reg, mul_b_reg;
    logic [1:0]           mul_mode_reg;
    logic                 err_reg;

    logic [TAG_W-1:0]     tag_mem [DEPTH];
    logic [PW-1:0]        tag_wr_ptr_reg, tag_rd_ptr_reg;
    logic                 tag_empty, tag_full;

    logic [RW-1:0]        res_mem [DEPTH];
    logic [PW-1:0]        res_wr_ptr_reg, res_rd_ptr_reg;
    logic                 res_empty, res_full;

    logic                 accept;
    logic                 res_push;
    logic                 rsp_pop;
    logic                 stray_done;
    logic [RW-1:0]        res_head;

    assign req_ready  = !rst && !mul_busy && (occ_reg < PW'(DEPTH));
    assign accept     = req_valid && req_ready;

    assign tag_empty  = (tag_wr_ptr_reg == tag_rd_ptr_reg);
    assign tag_full   = (tag_wr_ptr_reg[AW] != tag_rd_ptr_reg[AW]) &&
                        (tag_wr_ptr_reg[AW-1:0] == tag_rd_ptr_reg[AW-1:0]);
    assign res_empty  = (res_wr_ptr_reg == res_rd_ptr_reg);
    assign res_full   = (res_wr_ptr_reg[AW] != res_rd_ptr_reg[AW]) &&
                        (res_wr_ptr_reg[AW-1:0] == res_rd_ptr_reg[AW-1:0]);

    // A completion pairs with the oldest outstanding tag; without one it is dropped.
    assign res_push   = mul_done && !tag_empty;
    assign stray_done = mul_done && tag_empty;
    assign rsp_pop    = rsp_valid && rsp_ready;

    always_comb begin
        occ_next = occ_reg;
        case ({accept, rsp_pop})
            2'b10:   occ_next = occ_reg + PW'(1);
            2'b01:   occ_next = occ_reg - PW'(1);
            default: occ_next = occ_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_reg        <= '0;
            mul_start_reg  <= 1'b0;
            mul_a_reg      <= '0;
            mul_b_reg      <= '0;
            mul_mode_reg   <= '0;
            err_reg        <= 1'b0;
            tag_wr_ptr_reg <= '0;
            tag_rd_ptr_reg <= '0;
            res_wr_ptr_reg <= '0;
            res_rd_ptr_reg <= '0;
        end else begin
            occ_reg       <= occ_next;
            mul_start_reg <= accept;
            if (accept) begin
                mul_a_reg      <= req_a;
                mul_b_reg      <= req_b;
                mul_mode_reg   <= req_mode;
                tag_wr_ptr_reg <= tag_wr_ptr_reg + PW'(1);
            end
            if (res_push) begin
                tag_rd_ptr_reg <= tag_rd_ptr_reg + PW'(1);
                res_wr_ptr_reg <= res_wr_ptr_reg + PW'(1);
            end
            if (rsp_pop) begin
                res_rd_ptr_reg <= res_rd_ptr_reg + PW'(1);
            end
            if (stray_done) begin
                err_reg <= 1'b1;
            end
            assert (!(res_push && res_full));
            assert (!(accept && tag_full));
        end
    end

    // Storage arrays carry no reset; the pointers alone define valid contents.
    always_ff @(posedge clk) begin
        if (accept) begin
            tag_mem[tag_wr_ptr_reg[AW-1:0]] <= req_tag;
        end
        if (res_push) begin
            res_mem[res_wr_ptr_reg[AW-1:0]] <= {mul_product, tag_mem[tag_rd_ptr_reg[AW-1:0]]};
        end
    end

    assign res_head            = res_mem[res_rd_ptr_reg[AW-1:0]];
    assign rsp_valid           = !res_empty;
    assign rsp_product         = res_head[RW-1:TAG_W];
    assign rsp_tag             = res_head[TAG_W-1:0];

    assign mul_start           = mul_start_reg;
    assign mul_multiplicand    = mul_a_reg;
    assign mul_multiplier      = mul_b_reg;
    assign mul_sign_mode       = mul_mode_reg;
    assign err_unexpected_done = err_reg;

endmodule

// File: tb/tb_booth_mult_dispatcher.sv
// Directed bench for booth_mult_dispatcher with a 3-stage pipelined multiplier model.
module tb_booth_mult_dispatcher;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_a, req_b;
    logic [1:0]  req_mode;
    logic [3:0]  req_tag;
    logic        mul_start;
    logic [15:0] mul_multiplicand, mul_multiplier;
    logic [1:0]  mul_sign_mode;
    logic        mul_busy;
    logic        mul_done;
    logic [31:0] mul_product;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_product;
    logic [3:0]  rsp_tag;
    logic        err_unexpected_done;

    int checks = 0;
    int errors = 0;

    booth_mult_dispatcher #(.WIDTH(16), .TAG_W(4), .DEPTH(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_mode(req_mode), .req_tag(req_tag),
        .mul_start(mul_start), .mul_multiplicand(mul_multiplicand),
        .mul_multiplier(mul_multiplier), .mul_sign_mode(mul_sign_mode),
        .mul_busy(mul_busy), .mul_done(mul_done), .mul_product(mul_product),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_product(rsp_product), .rsp_tag(rsp_tag),
        .err_unexpected_done(err_unexpected_done)
    );

    always #5 clk = ~clk;

    // Multiplier model: fixed 3-cycle pipeline, reset together with the dispatcher.
    logic [2:0]  pipe_v;
    logic [31:0] p0, p1, p2;
    logic        inject_done;

    function automatic logic [31:0] model_mult(input logic [15:0] a, input logic [15:0] b,
                                               input logic [1:0] m);
        longint ae, be;
        ae = m[1] ? longint'($signed(a)) : longint'({16'b0, a});
        be = m[0] ? longint'($signed(b)) : longint'({16'b0, b});
        return 32'(ae * be);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            pipe_v <= '0;
        end else begin
            pipe_v <= {pipe_v[1:0], mul_start};
            p0     <= model_mult(mul_multiplicand, mul_multiplier, mul_sign_mode);
            p1     <= p0;
            p2     <= p1;
        end
    end

    assign mul_done    = pipe_v[2] | inject_done;
    assign mul_product = inject_done ? 32'hDEAD_BEEF : p2;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [1:0] m,
                        input logic [3:0] t);
        req_valid = 1'b1; req_a = a; req_b = b; req_mode = m; req_tag = t;
        #1;
        chk("send_ready", 64'(req_ready), 64'd1);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic pop_chk(input string name, input logic [31:0] prod, input logic [3:0] tag);
        int n;
        n = 0;
        while (!rsp_valid && n < 50) begin
            tick();
            n++;
        end
        chk({name, "_valid"}, 64'(rsp_valid), 64'd1);
        chk({name, "_product"}, 64'(rsp_product), 64'(prod));
        chk({name, "_tag"}, 64'(rsp_tag), 64'(tag));
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        int accepted;
        rst = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; req_mode = '0; req_tag = '0;
        mul_busy = 1'b0; rsp_ready = 1'b0; inject_done = 1'b0;
        tick(); tick(); tick();

        // Reset state
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_mul_start", 64'(mul_start), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_err", 64'(err_unexpected_done), 64'd0);
        chk("rst_operands", 64'({mul_multiplicand, mul_multiplier, mul_sign_mode}), 64'd0);
        rst = 1'b0;
        #1;
        chk("idle_ready", 64'(req_ready), 64'd1);

        // Single request: 10*10, one start pulse one cycle after accept
        send(16'd10, 16'd10, 2'b11, 4'd3);
        chk("start_pulse", 64'(mul_start), 64'd1);
        chk("start_ops", 64'({mul_multiplicand, mul_multiplier, mul_sign_mode}),
            64'({16'd10, 16'd10, 2'b11}));
        tick();
        chk("start_once", 64'(mul_start), 64'd0);
        chk("ops_hold", 64'(mul_multiplicand), 64'd10);
        pop_chk("r10x10", 32'd100, 4'd3);
        chk("drained_1", 64'(rsp_valid), 64'd0);

        // Back-to-back accepts
        req_valid = 1'b1; req_a = 16'h7FFF; req_b = 16'd1; req_mode = 2'b11; req_tag = 4'd0;
        #1;
        chk("b2b_ready0", 64'(req_ready), 64'd1);
        tick();
        chk("b2b_start0", 64'(mul_start), 64'd1);
        req_a = 16'h8000; req_tag = 4'd1;
        #1;
        chk("b2b_ready1", 64'(req_ready), 64'd1);
        tick();
        req_valid = 1'b0;
        chk("b2b_start1", 64'(mul_start), 64'd1);
        chk("b2b_ops1", 64'(mul_multiplicand), 64'h8000);
        pop_chk("b2b_first", 32'h0000_7FFF, 4'd0);
        pop_chk("b2b_second", 32'hFFFF_8000, 4'd1);

        // Sign modes on all-ones operands
        send(16'hFFFF, 16'hFFFF, 2'b00, 4'd5);
        pop_chk("uu_ffff", 32'hFFFE_0001, 4'd5);
        send(16'hFFFF, 16'hFFFF, 2'b11, 4'd6);
        pop_chk("ss_ffff", 32'h0000_0001, 4'd6);
        send(16'hFFFF, 16'hFFFF, 2'b10, 4'd7);
        pop_chk("su_ffff", 32'hFFFF_0001, 4'd7);

        // Busy multiplier blocks acceptance
        mul_busy = 1'b1;
        #1;
        chk("busy_blocks", 64'(req_ready), 64'd0);
        mul_busy = 1'b0;
        #1;
        chk("busy_release", 64'(req_ready), 64'd1);

        // Fill to DEPTH with the consumer stalled
        accepted = 0;
        for (int i = 0; i < 10; i++) begin
            req_valid = 1'b1; req_a = 16'(i + 1); req_b = 16'd2; req_mode = 2'b00; req_tag = 4'(i);
            #1;
            if (req_ready) accepted++;
            tick();
        end
        req_valid = 1'b0;
        chk("fill_accepted", 64'(accepted), 64'd8);
        for (int i = 0; i < 6; i++) tick();
        chk("full_ready", 64'(req_ready), 64'd0);
        chk("full_rsp_valid", 64'(rsp_valid), 64'd1);
        for (int i = 0; i < 8; i++) begin
            pop_chk($sformatf("drain%0d", i), 32'((i + 1) * 2), 4'(i));
        end
        chk("drain_empty", 64'(rsp_valid), 64'd0);
        chk("drain_reopen", 64'(req_ready), 64'd1);

        // Unexpected completion
        inject_done = 1'b1;
        tick();
        inject_done = 1'b0;
        chk("stray_err", 64'(err_unexpected_done), 64'd1);
        chk("stray_no_rsp", 64'(rsp_valid), 64'd0);
        tick(); tick();
        chk("stray_sticky", 64'(err_unexpected_done), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("stray_cleared", 64'(err_unexpected_done), 64'd0);

        // Reset mid-burst after 3 of 5 accepts
        req_valid = 1'b1; req_b = 16'd3; req_mode = 2'b00;
        for (int i = 0; i < 3; i++) begin
            req_a = 16'(i + 1); req_tag = 4'(i);
            tick();
        end
        rst = 1'b1;
        req_a = 16'd4; req_tag = 4'd3;
        tick();
        chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("mid_rst_start", 64'(mul_start), 64'd0);
        chk("mid_rst_ready", 64'(req_ready), 64'd0);
        rst = 1'b0;
        req_valid = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("post_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("post_rst_err", 64'(err_unexpected_done), 64'd0);
        send(16'd7, 16'hFFFD, 2'b11, 4'd9);
        pop_chk("post_rst", 32'hFFFF_FFEB, 4'd9);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
